// File: rtl/ryuki_datatypes.sv
// Shared processor datatypes: trace record layout and the trace source identifier.
package ryuki_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
  } trace_output;

  // 0 = IF/ID trace source, 1 = data-memory trace source
  typedef logic trace_src_t;

  typedef struct packed {
    trace_src_t  src;
    trace_output rec;
  } trace_entry_t;

endpackage

// File: rtl/trace_arbiter_if.sv
// Valid/ready handshake carrying one trace record; master drives valid and data.
interface trace_arbiter_if;
  import ryuki_datatypes::*;

  logic        valid;
  logic        ready;
  trace_output data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/trace_fifo.sv
// Power-of-two circular FIFO with a combinational head read and synchronous flush.
module trace_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type payload_t = logic
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  payload_t               push_data,
  input  logic                   pop,
  output payload_t               head_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(DEPTH);

  payload_t        mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   level_q, level_d;
  logic            push_eff, pop_eff;

  always_comb begin
    push_eff = push & (level_q != LevelFull) & ~flush;
    pop_eff  = pop & (level_q != '0) & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH
      if (push_eff) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_eff, pop_eff})
        2'b10:   level_d = level_q + (PtrW + 1)'(1);
        2'b01:   level_d = level_q - (PtrW + 1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; contents are only observed through a valid level
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_q] <= push_data;
  end

  assign head_data = mem[rd_ptr_q];
  assign level     = level_q;
  assign full      = (level_q == LevelFull);

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin merge of two trace sources into one buffered trace stream with a stall counter.
module trace_arbiter
  import ryuki_datatypes::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STALL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  trace_arbiter_if.slave         src0,
  trace_arbiter_if.slave         src1,
  trace_arbiter_if.master        trace,
  output trace_src_t             trace_src,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [STALL_WIDTH-1:0] stall_count
);

  trace_src_t             last_grant_q, last_grant_d;
  logic                   sel0, sel1;
  logic                   full, push, pop, blocked;
  trace_entry_t           push_entry, head_entry;
  logic [STALL_WIDTH-1:0] stall_q, stall_d;

  trace_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (trace_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .level     (fifo_level),
    .full      (full)
  );

  // Under contention the source that did not win last time is selected
  always_comb begin
    sel1 = src1.valid & (~src0.valid | (last_grant_q == 1'b0));
    sel0 = src0.valid & ~sel1;
    // No push-through when full, even if the sink pops this cycle
    src0.ready = sel0 & ~full & ~flush & rst;
    src1.ready = sel1 & ~full & ~flush & rst;
    push = src0.ready | src1.ready;
    push_entry.src = src1.ready;
    push_entry.rec = sel1 ? src1.data : src0.data;
    last_grant_d = push ? trace_src_t'(src1.ready) : last_grant_q;
  end

  always_comb begin
    trace.valid = (fifo_level != '0);
    trace.data  = head_entry.rec;
    trace_src   = head_entry.src;
    pop         = trace.valid & trace.ready;
  end

  always_comb begin
    blocked = (src0.valid & ~src0.ready) | (src1.valid & ~src1.ready);
    stall_d = stall_q;
    if (blocked && (stall_q != '1)) stall_d = stall_q + STALL_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      stall_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: arbitration, fill, full-with-pop, wrap, flush, async reset.
module tb_trace_arbiter;
  import ryuki_datatypes::*;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned STALL_WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   flush = 1'b0;
  trace_src_t             trace_src;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [STALL_WIDTH-1:0] stall_count;
  int                     checks = 0;
  int                     errors = 0;

  trace_arbiter_if src0 ();
  trace_arbiter_if src1 ();
  trace_arbiter_if trace ();

  trace_arbiter #(
    .DEPTH       (DEPTH),
    .STALL_WIDTH (STALL_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src0        (src0),
    .src1        (src1),
    .trace       (trace),
    .trace_src   (trace_src),
    .flush       (flush),
    .fifo_level  (fifo_level),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  function automatic trace_output mk(input logic [31:0] v);
    trace_output r;
    r.pc       = v;
    r.instr    = v ^ 32'hA5A5_0000;
    r.mem_addr = v << 2;
    r.mem_data = ~v;
    r.mem_we   = v[0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    src0.valid  = 1'b0;
    src0.data   = mk(32'h0);
    src1.valid  = 1'b0;
    src1.data   = mk(32'h0);
    trace.ready = 1'b0;

    // Reset state
    #12;
    chk("rst_level", fifo_level, 0);
    chk("rst_tvalid", trace.valid, 0);
    chk("rst_stall", stall_count, 0);
    src0.valid = 1'b1;
    #1;
    chk("rst_r0", src0.ready, 0);
    src0.valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Round robin with both sources always valid
    src0.valid = 1'b1; src0.data = mk(32'h100);
    src1.valid = 1'b1; src1.data = mk(32'h200);
    trace.ready = 1'b1;
    #1;
    chk("arb0_r0", src0.ready, 1);
    chk("arb0_r1", src1.ready, 0);
    tick; src0.data = mk(32'h101); #1;
    chk("arb1_r0", src0.ready, 0);
    chk("arb1_r1", src1.ready, 1);
    chk("arb1_src", trace_src, 0);
    chk("arb1_data", trace.data, mk(32'h100));
    tick; src1.data = mk(32'h201); #1;
    chk("arb2_r0", src0.ready, 1);
    chk("arb2_src", trace_src, 1);
    chk("arb2_data", trace.data, mk(32'h200));
    chk("arb2_level", fifo_level, 1);
    tick; src0.data = mk(32'h102); #1;
    chk("arb3_r1", src1.ready, 1);
    chk("arb3_src", trace_src, 0);
    chk("arb3_data", trace.data, mk(32'h101));
    tick; src1.data = mk(32'h202); #1;
    chk("arb4_src", trace_src, 1);
    chk("arb4_data", trace.data, mk(32'h201));
    chk("arb4_stall", stall_count, 4);
    src0.valid = 1'b0; src1.valid = 1'b0;
    tick;
    chk("arb_drain_level", fifo_level, 0);
    chk("arb_drain_tvalid", trace.valid, 0);
    chk("arb_drain_stall", stall_count, 4);

    // Fill to full from src0 with the sink stalled
    trace.ready = 1'b0;
    src0.valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src0.data = mk(32'h10 + 32'((i < 4) ? i : 4));
      #1;
      if (i == 0) chk("fill_r0_first", src0.ready, 1);
      if (i == 4) chk("fill_r0_full", src0.ready, 0);
      tick;
    end
    src0.valid = 1'b0;
    chk("fill_level", fifo_level, 4);
    chk("fill_stall", stall_count, 6);
    chk("fill_tvalid", trace.valid, 1);

    // Full with a simultaneous pop: no push-through
    src1.valid = 1'b1; src1.data = mk(32'h20);
    trace.ready = 1'b1;
    #1;
    chk("fullpop_r1", src1.ready, 0);
    chk("fullpop_head", trace.data, mk(32'h10));
    tick;
    chk("fullpop_level", fifo_level, 3);
    chk("fullpop_r1_next", src1.ready, 1);
    chk("fullpop_head2", trace.data, mk(32'h11));
    tick; src1.valid = 1'b0; #1;
    chk("fullpop_level2", fifo_level, 3);
    chk("drain_h12", trace.data, mk(32'h12));
    tick;
    chk("drain_h13", trace.data, mk(32'h13));
    tick;
    chk("drain_h20", trace.data, mk(32'h20));
    chk("drain_src1", trace_src, 1);
    tick;
    chk("drain_level", fifo_level, 0);
    chk("drain_stall", stall_count, 7);

    // Wrap-around: ten records streamed through one per cycle
    for (int i = 1; i <= 10; i++) begin
      src0.valid = 1'b1;
      src0.data  = mk(32'(i));
      #1;
      chk("wrap_r0", src0.ready, 1);
      if (i > 1) chk("wrap_head", trace.data, mk(32'(i - 1)));
      tick;
    end
    src0.valid = 1'b0;
    #1;
    chk("wrap_last", trace.data, mk(32'hA));
    chk("wrap_tvalid", trace.valid, 1);
    tick;
    chk("wrap_level", fifo_level, 0);
    chk("wrap_stall", stall_count, 7);

    // Flush with three buffered, src0 offering and sink ready
    trace.ready = 1'b0;
    src0.valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src0.data = mk(32'h30 + 32'(i));
      tick;
    end
    chk("flush_pre_level", fifo_level, 3);
    flush = 1'b1; src0.data = mk(32'h33); trace.ready = 1'b1;
    #1;
    chk("flush_r0", src0.ready, 0);
    tick;
    flush = 1'b0; src0.valid = 1'b0;
    #1;
    chk("flush_level", fifo_level, 0);
    chk("flush_tvalid", trace.valid, 0);
    chk("flush_stall", stall_count, 8);
    src0.valid = 1'b1; src1.valid = 1'b1; src1.data = mk(32'h60);
    #1;
    chk("flush_grant_r1", src1.ready, 1);
    chk("flush_grant_r0", src0.ready, 0);
    src0.valid = 1'b0; src1.valid = 1'b0;
    #1;

    // Asynchronous reset with two records buffered
    trace.ready = 1'b0;
    src0.valid  = 1'b1; src0.data = mk(32'h40);
    tick; src0.data = mk(32'h41);
    tick; src0.valid = 1'b0;
    chk("ares_pre_level", fifo_level, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("ares_tvalid", trace.valid, 0);
    chk("ares_level", fifo_level, 0);
    chk("ares_stall", stall_count, 0);
    src1.valid = 1'b1; src1.data = mk(32'h50);
    #1;
    chk("ares_r1_held", src1.ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("ares_r1_release", src1.ready, 1);
    tick; src1.valid = 1'b0; #1;
    chk("ares_post_level", fifo_level, 1);
    chk("ares_post_src", trace_src, 1);
    chk("ares_post_data", trace.data, mk(32'h50));
    chk("ares_post_stall", stall_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the FIFO entry count; legal values are powers of two, 2 to 16.
REQ-002 Parameter STALL_WIDTH, default 16, SHALL set the width of stall_count.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 src0_valid  input  1  SHALL indicate that the IF/ID trace record on src0_data is offered.
REQ-006 src0_data  input  trace_output  SHALL carry the IF/ID trace record.
REQ-007 src0_ready  output  1  SHALL indicate that the src0 record is accepted this cycle.
REQ-008 src1_valid, src1_data, src1_ready SHALL match REQ-005 to REQ-007 for the data-memory trace source.
REQ-009 trace_valid  output  1  SHALL indicate that the FIFO head is presented downstream.
REQ-010 trace_ready  input  1  SHALL indicate that the sink consumes the head this cycle.
REQ-011 trace_data  output  trace_output  SHALL carry the FIFO head record.
REQ-012 trace_src  output  1  SHALL carry the source ID of the head record (0 = src0, 1 = src1).
REQ-013 flush  input  1  SHALL be a synchronous clear of all FIFO contents.
REQ-014 fifo_level  output  $clog2(DEPTH)+1  SHALL report the current entry count.
REQ-015 stall_count  output  STALL_WIDTH  SHALL report the number of cycles in which a source was blocked.

Function
REQ-016 Handshake: a transfer SHALL occur on any clock edge where valid and ready are both high; a source SHALL hold its valid and data stable until accepted.
REQ-017 Arbitration: the block SHALL accept at most one record per cycle, chosen by round robin over the last_grant register.
- Only one source valid: that source is selected.
- Both valid: the source not equal to last_grant is selected.
- last_grant SHALL update only on an accepted push.
REQ-018 srcN_ready SHALL be combinational and high only when srcN is selected, the FIFO is not full, and flush is low.
REQ-019 When the FIFO is full, both readies SHALL be low, even if a pop happens in the same cycle (no push-through when full).
REQ-020 When the FIFO is empty, a pushed record SHALL appear on trace_valid/trace_data/trace_src on the cycle after acceptance (one-cycle latency); there SHALL be no combinational bypass.
REQ-021 trace_valid SHALL equal (fifo_level != 0), and trace_data/trace_src SHALL be the head entry, read combinationally from storage.
REQ-022 A push and a pop in the same cycle SHALL leave fifo_level unchanged, and both SHALL take effect.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH.
REQ-024 flush SHALL take priority over push and pop: on the next edge, pointers and fifo_level SHALL be 0, the pending pop SHALL be discarded, and last_grant SHALL be unchanged.
REQ-025 stall_count SHALL increment on each cycle where (src0_valid & ~src0_ready) | (src1_valid & ~src1_ready), counting at most 1 per cycle.
REQ-026 stall_count SHALL saturate at all-ones, and flush SHALL NOT clear it.
REQ-027 The stored record and trace_src SHALL be passed through unmodified; no field of trace_output SHALL be altered.

Reset
REQ-028 While rst is low, the block SHALL be held in reset, asynchronously: pointers = 0, fifo_level = 0, last_grant = 1 (src0 wins the first contention), stall_count = 0.
REQ-029 During reset, trace_valid, src0_ready and src1_ready SHALL be 0; FIFO storage contents are don't-care.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered records; the first push after release SHALL be accepted in the first cycle with rst high.

Structure
REQ-031 The trace_output typedef SHALL remain in ryuki_datatypes; a trace_src_t (1-bit) typedef SHALL be added to that package.
REQ-032 FIFO storage and pointers SHALL be a sub-module, trace_fifo (parameters DEPTH and payload type), with the arbiter and stall counter kept in trace_arbiter.

Verification
REQ-033 Arbitration: after reset, both sources valid continuously, trace_ready = 1 -> accept order src0, src1, src0, src1; trace_src sequence 0, 1, 0, 1.
REQ-034 Fill: trace_ready = 0, src0 valid for 6 cycles, DEPTH = 4 -> 4 accepted, fifo_level = 4, src0_ready low for the remaining 2 cycles, stall_count = 2.
REQ-035 Full with pop: FIFO full, trace_ready = 1 and src1 valid in the same cycle -> src1_ready = 0, fifo_level = 3 next cycle, src1 accepted the following cycle.
REQ-036 Wrap-around: push 10 records with distinct payloads 0x1 to 0xA, pop 1 per cycle -> output order 0x1 to 0xA, with no loss or duplication.
REQ-037 Flush: fifo_level = 3, flush pulsed with src0 valid and trace_ready = 1 -> next cycle fifo_level = 0, trace_valid = 0, src0 not accepted in the flush cycle.
REQ-038 Async reset: rst driven low between clock edges with 2 entries buffered -> trace_valid = 0 immediately and fifo_level = 0; after release, src1-only valid -> accepted on the first cycle with rst high.
